// File: rtl/ssd_multi.sv
// ssd_multi: multi-digit seven-segment display driver.
// A request arrives as a binary value. In decimal mode the value goes through a
// sequential shift-add-3 (double-dabble) conversion, one bit per cycle. In hex
// mode the value is split straight into nibbles. The result drives DIGITS
// active-low digits. Leading zeros can be blanked, and values that do not fit
// in DIGITS digits are shown as dashes.
//
// Ports
//   clock     rising-edge clock
//   reset     synchronous, active-high reset
//   load      request to display value; only honoured while idle
//   value     unsigned binary value to display (WIDTH bits)
//   hex_mode  1 = hexadecimal, 0 = decimal; captured together with load
//   blank_lz  1 = blank leading zeros; captured together with load
//   busy      high while a request is in progress
//   done      one-cycle pulse in the cycle seg/overflow change
//   overflow  the last request did not fit in DIGITS digits
//   seg       active-low segments; bits [7i+6:7i] belong to digit i, order gfedcba

module ssd_multi_digit (
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg7
);
    always_comb begin
        seg7 = 7'b1111111;
        if (dash) begin
            seg7 = 7'b0111111;
        end else if (!blank) begin
            case (nib)
                4'h0: seg7 = 7'b1000000;
                4'h1: seg7 = 7'b1111001;
                4'h2: seg7 = 7'b0100100;
                4'h3: seg7 = 7'b0110000;
                4'h4: seg7 = 7'b0011001;
                4'h5: seg7 = 7'b0010010;
                4'h6: seg7 = 7'b0000010;
                4'h7: seg7 = 7'b1111000;
                4'h8: seg7 = 7'b0000000;
                4'h9: seg7 = 7'b0010000;
                4'hA: seg7 = 7'b0001000;
                4'hB: seg7 = 7'b0000011;
                4'hC: seg7 = 7'b1000110;
                4'hD: seg7 = 7'b0100001;
                4'hE: seg7 = 7'b0000110;
                default: seg7 = 7'b0001110;
            endcase
        end
    end
endmodule

module ssd_multi #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*7-1:0]   seg
);
    localparam int BW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int EW = (WIDTH > BW) ? WIDTH : BW;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]    shreg;       // captured value; shifted out MSB-first in decimal mode
    logic                hex_r;
    logic                blz_r;
    logic [BW-1:0]       bcd;
    logic                ovf_sticky;
    logic [CW-1:0]       cnt;

    logic [BW-1:0]       adj;
    logic [EW-1:0]       hex_ext;
    logic                hex_ovf;
    logic [BW-1:0]       nib;
    logic                ovf_now;
    logic [DIGITS-1:0]   blank;
    logic                lead;
    logic [DIGITS*7-1:0] seg_next;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = hex_mode ? UPDATE : SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble, applied before the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg      <= '0;
            hex_r      <= 1'b0;
            blz_r      <= 1'b0;
            bcd        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    shreg      <= value;
                    hex_r      <= hex_mode;
                    blz_r      <= blank_lz;
                    bcd        <= '0;
                    ovf_sticky <= 1'b0;
                    cnt        <= CW'(WIDTH);
                end
                SHIFT: begin
                    bcd   <= {adj[BW-2:0], shreg[WIDTH-1]};
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    // A set bit leaving the top of the BCD register means the
                    // decimal value needs more than DIGITS digits.
                    if (adj[BW-1]) ovf_sticky <= 1'b1;
                    cnt   <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Hex view: value zero-extended to at least DIGITS nibbles.
    always_comb begin
        hex_ext = '0;
        hex_ext[WIDTH-1:0] = shreg;
    end

    generate
        if (EW > BW) begin : g_hex_ovf
            assign hex_ovf = |hex_ext[EW-1:BW];
        end else begin : g_hex_fit
            assign hex_ovf = 1'b0;
        end
    endgenerate

    assign nib     = hex_r ? hex_ext[BW-1:0] : bcd;
    assign ovf_now = hex_r ? hex_ovf : ovf_sticky;

    // Walk from the top digit down; a digit is blanked while every digit so far is zero.
    always_comb begin
        blank = '0;
        lead  = blz_r;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead & (nib[4*i +: 4] == 4'd0);
            if (i != 0) blank[i] = lead;
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_dig
            ssd_multi_digit u_dig (
                .nib   (nib[4*g +: 4]),
                .blank (blank[g]),
                .dash  (ovf_now),
                .seg7  (seg_next[7*g +: 7])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            seg      <= '1;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= (state == UPDATE);
            busy <= (state_next != IDLE);
            if (state == UPDATE) begin
                seg      <= seg_next;
                overflow <= ovf_now;
            end
        end
    end
endmodule

// File: tb/tb_ssd_multi.sv
// Bench for ssd_multi. Two instances (DIGITS=5 and DIGITS=4) share the stimulus.
// Expected displays come from a digit-arithmetic model.
module tb_ssd_multi;
    logic        clock = 1'b0;
    logic        reset, load, hex_mode, blank_lz;
    logic [15:0] value;
    logic        busy5, done5, ovf5;
    logic [34:0] seg5;
    logic        busy4, done4, ovf4;
    logic [27:0] seg4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ssd_multi #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .hex_mode(hex_mode), .blank_lz(blank_lz),
        .busy(busy5), .done(done5), .overflow(ovf5), .seg(seg5)
    );

    ssd_multi #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .hex_mode(hex_mode), .blank_lz(blank_lz),
        .busy(busy4), .done(done4), .overflow(ovf4), .seg(seg4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic longint unsigned limit(input bit hx, input int nd);
        longint unsigned lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * (hx ? 16 : 10);
        return lim;
    endfunction

    function automatic bit model_ovf(input int unsigned v, input bit hx, input int nd);
        return longint'(v) >= limit(hx, nd);
    endfunction

    function automatic logic [34:0] model_seg(input int unsigned v, input bit hx, input bit blz, input int nd);
        logic [34:0] res;
        int unsigned base, t;
        int dg[5];
        int ms;
        res  = '1;
        base = hx ? 16 : 10;
        if (model_ovf(v, hx, nd)) begin
            for (int i = 0; i < nd; i++) res[7*i +: 7] = 7'b0111111;
        end else begin
            t = v;
            for (int i = 0; i < nd; i++) begin
                dg[i] = int'(t % base);
                t     = t / base;
            end
            ms = 0;  // most significant nonzero digit position
            for (int i = 0; i < nd; i++) if (dg[i] != 0) ms = i;
            for (int i = 0; i < nd; i++)
                res[7*i +: 7] = (blz && i > ms) ? 7'b1111111 : enc(dg[i]);
        end
        return res;
    endfunction

    // Present a request for one edge, then scramble the inputs.
    task automatic start(input int unsigned v, input bit hx, input bit blz);
        value    = 16'(v);
        hex_mode = hx;
        blank_lz = blz;
        load     = 1'b1;
        @(posedge clock); #1;
        load     = 1'b0;
        value    = 16'($urandom);
        hex_mode = 1'($urandom_range(0, 1));
        blank_lz = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int unsigned v, input bit hx, input bit blz,
                             input int exp_busy, input string tag);
        int t  = 0;
        int nb = 0;
        logic [34:0] e5, e4;
        while (done5 !== 1'b1 && t < 40) begin
            if (busy5 === 1'b1) nb++;
            @(posedge clock); #1;
            t++;
        end
        chk({tag, ":done_seen"}, 64'(t < 40), 64'(1));
        if (exp_busy >= 0) chk({tag, ":busy_cycles"}, 64'(nb), 64'(exp_busy));
        e5 = model_seg(v, hx, blz, 5);
        e4 = model_seg(v, hx, blz, 4);
        chk({tag, ":seg5"}, 64'(seg5), 64'(e5));
        chk({tag, ":ovf5"}, 64'(ovf5), 64'(model_ovf(v, hx, 5)));
        chk({tag, ":seg4"}, 64'(seg4), 64'(e4[27:0]));
        chk({tag, ":ovf4"}, 64'(ovf4), 64'(model_ovf(v, hx, 4)));
        chk({tag, ":done4"}, 64'(done4), 64'(1));
    endtask

    task automatic req(input int unsigned v, input bit hx, input bit blz, input string tag);
        @(negedge clock);
        start(v, hx, blz);
        wait_done(v, hx, blz, hx ? 1 : 17, tag);
        @(posedge clock); #1;
        chk({tag, ":done_one_cycle"}, 64'(done5), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int unsigned rv;
        reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst:seg5", 64'(seg5), 64'({35{1'b1}}));
        chk("rst:seg4", 64'(seg4), 64'({28{1'b1}}));
        chk("rst:busy", 64'(busy5), 64'(0));
        chk("rst:done", 64'(done5), 64'(0));
        chk("rst:ovf",  64'(ovf5), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // Directed cases
        req(1234, 0, 1, "dec1234");
        req(16'hBEEF, 1, 0, "hexBEEF");
        req(16'hBEEF, 1, 1, "hexBEEF_blz");
        req(0, 0, 1, "zero_blz");
        req(0, 1, 0, "zero_hex");
        req(65535, 0, 0, "dec_max");
        req(10000, 0, 0, "dec10000");
        req(16'h1234, 1, 0, "hex1234");
        req(9999, 0, 0, "dec9999");
        req(16'h0FFFF, 1, 1, "hexFFFF");
        req(1000, 0, 1, "dec1000_blz");

        // Load during a conversion is dropped
        @(negedge clock);
        start(77, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        load = 1'b1; value = 16'd42;
        repeat (2) @(posedge clock);
        #1;
        load = 1'b0;
        wait_done(77, 0, 0, -1, "hs77");
        nd = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done5 === 1'b1) nd++;
        end
        chk("hs:extra_done", 64'(nd), 64'(0));
        chk("hs:busy_idle", 64'(busy5), 64'(0));

        // Load in the done cycle is accepted
        @(negedge clock);
        start(300, 0, 1);
        wait_done(300, 0, 1, 17, "b2b_a");
        start(16'h0555, 1, 0);
        wait_done(16'h0555, 1, 0, 1, "b2b_b");

        // Reset at the 5th SHIFT edge
        @(negedge clock);
        start(1234, 0, 0);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst:seg5", 64'(seg5), 64'({35{1'b1}}));
        chk("midrst:busy", 64'(busy5), 64'(0));
        chk("midrst:done", 64'(done5), 64'(0));
        reset = 1'b0;
        nd = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done5 === 1'b1) nd++;
        end
        chk("midrst:no_done", 64'(nd), 64'(0));
        req(8, 0, 1, "after_rst8");

        // Random requests
        repeat (30) begin
            rv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 65535);
            req(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
